// File: rtl/kernel_prod_accum_if.sv
// Handshake bundle between the kernel controller/multiplier side and the product accumulator.
// The master modport drives start, length, products and result acceptance; the slave is the accumulator.
interface kernel_prod_accum_if #(
   parameter int DIN_WIDTH = 32,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 16
);
   logic                 ap_start;
   logic [LEN_WIDTH-1:0] len;
   logic [DIN_WIDTH-1:0] din;
   logic                 din_valid;
   logic                 din_ready;
   logic [ACC_WIDTH-1:0] dout;
   logic                 dout_valid;
   logic                 dout_ready;
   logic                 ovf;
   logic                 ap_idle;
   logic                 ap_done;

   modport master (
      output ap_start, len, din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, ovf, ap_idle, ap_done
   );

   modport slave (
      input  ap_start, len, din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, ovf, ap_idle, ap_done
   );
endinterface

// File: rtl/kernel_prod_accum.sv
// Signed streaming accumulator: sums len products at one per cycle, result valid the cycle after the last one.
// din stalls outside ACCUM; the result is held stable until dout_ready, then ap_done pulses with ap_idle.
module kernel_prod_accum #(
   parameter int DIN_WIDTH = 32,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 16
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   kernel_prod_accum_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic        [LEN_WIDTH-1:0] r_rem;
   logic                        r_ovf;
   logic                        r_done;

   logic                        w_start;
   logic                        w_din_hs;
   logic                        w_dout_hs;
   logic                        w_last;
   logic signed [DIN_WIDTH-1:0] w_din_s;
   logic signed [ACC_WIDTH-1:0] w_din_ext;
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic                        w_add_ovf;

   assign w_start   = (r_state == S_IDLE)   && bus.ap_start;
   assign w_din_hs  = (r_state == S_ACCUM)  && bus.din_valid;
   assign w_dout_hs = (r_state == S_OUTPUT) && bus.dout_ready;
   assign w_last    = (r_rem == LEN_WIDTH'(1));

   assign w_din_s   = bus.din;
   assign w_din_ext = ACC_WIDTH'(w_din_s);
   assign w_sum     = r_acc + w_din_ext;
   // Signed overflow: operands agree in sign but the wrapped sum does not.
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_din_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.ap_start) begin
               w_state_nxt = (bus.len == '0) ? S_OUTPUT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_din_hs && w_last) begin
               w_state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (bus.dout_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_acc  <= '0;
         r_rem  <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_dout_hs;
         if (w_start) begin
            r_acc <= '0;
            r_rem <= bus.len;
            r_ovf <= 1'b0;
         end else if (w_din_hs) begin
            r_acc <= w_sum;
            r_rem <= r_rem - LEN_WIDTH'(1);
            if (w_add_ovf) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign bus.din_ready  = (r_state == S_ACCUM);
   assign bus.dout_valid = (r_state == S_OUTPUT);
   assign bus.ap_idle    = (r_state == S_IDLE);
   assign bus.dout       = r_acc;
   assign bus.ovf        = r_ovf;
   assign bus.ap_done    = r_done;
endmodule

// File: tb/tb_kernel_prod_accum.sv
// Directed bench for kernel_prod_accum: inputs driven and outputs sampled on the falling clock edge.
module tb_kernel_prod_accum;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int LW = 16;

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 ap_clk = ~ap_clk;

   kernel_prod_accum_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   kernel_prod_accum #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   task automatic idle_inputs();
      bus.ap_start   = 1'b0;
      bus.len        = '0;
      bus.din        = '0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
   endtask

   task automatic start_run(input int n);
      bus.len      = LW'(n);
      bus.ap_start = 1'b1;
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
   endtask

   task automatic feed(input logic [DW-1:0] v);
      bus.din       = v;
      bus.din_valid = 1'b1;
      @(negedge ap_clk);
      bus.din_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit timed_out);
      int c = 0;
      while (!bus.dout_valid && c < budget) begin
         @(negedge ap_clk);
         c++;
      end
      timed_out = !bus.dout_valid;
   endtask

   task automatic take_result();
      bus.dout_ready = 1'b1;
      @(negedge ap_clk);
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit to;
      idle_inputs();
      ap_rst_n = 1'b0;
      repeat (2) @(negedge ap_clk);
      n_checks++;
      if (bus.ap_idle !== 1'b1 || bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b0 ||
          bus.ap_done !== 1'b0 || bus.ovf !== 1'b0 || bus.dout !== '0) begin
         n_fail++;
         $display("FAIL reset_values idle=%b dv=%b dr=%b done=%b ovf=%b dout=%h required 1 0 0 0 0 00000000",
                  bus.ap_idle, bus.dout_valid, bus.din_ready, bus.ap_done, bus.ovf, bus.dout);
      end
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      start_run(5);
      feed(1); feed(2); feed(3);
      n_checks++;
      if (bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_accum_ready got=%b required 1", bus.din_ready);
      end
      ap_rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.ap_idle !== 1'b1 || bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b0 ||
          bus.ap_done !== 1'b0 || bus.ovf !== 1'b0 || bus.dout !== '0) begin
         n_fail++;
         $display("FAIL async_abort idle=%b dv=%b dr=%b done=%b ovf=%b dout=%h required 1 0 0 0 0 00000000",
                  bus.ap_idle, bus.dout_valid, bus.din_ready, bus.ap_done, bus.ovf, bus.dout);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (3) begin
         @(negedge ap_clk);
         n_checks++;
         if (bus.dout_valid !== 1'b0 || bus.ap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle dv=%b idle=%b required 0 1", bus.dout_valid, bus.ap_idle);
         end
      end
      start_run(2);
      feed(4); feed(5);
      wait_valid(4, to);
      n_checks++;
      if (to || bus.dout !== 32'd9) begin
         n_fail++;
         $display("FAIL restart_sum timeout=%b dout=%0d required 9", to, $signed(bus.dout));
      end
      take_result();
   endtask

   task automatic test_basic();
      int early = 0;
      start_run(4);
      for (int i = 0; i < 4; i++) begin
         if (bus.dout_valid) early++;
         case (i)
            0: feed(32'd3);
            1: feed(-32'sd7);
            2: feed(32'd10);
            default: feed(32'd100);
         endcase
      end
      n_checks++;
      if (early != 0 || bus.dout_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency early=%0d dv_at_5=%b required 0 1", early, bus.dout_valid);
      end
      n_checks++;
      if (bus.dout !== 32'd106 || bus.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_sum dout=%0d ovf=%b required 106 0", $signed(bus.dout), bus.ovf);
      end
      take_result();
      n_checks++;
      if (bus.ap_done !== 1'b1 || bus.ap_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_done done=%b idle=%b required 1 1", bus.ap_done, bus.ap_idle);
      end
      @(negedge ap_clk);
      n_checks++;
      if (bus.ap_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_pulse done=%b required 0", bus.ap_done);
      end
   endtask

   task automatic test_backpressure();
      bit [5:0] pat = 6'b101001;
      int k = 0;
      int pulses = 0;
      start_run(3);
      for (int i = 0; i < 6; i++) begin
         bus.din_valid = pat[i];
         bus.din       = pat[i] ? DW'(-(k + 1)) : 32'h1234_5678;
         @(negedge ap_clk);
         if (pat[i]) k++;
      end
      bus.din_valid = 1'b0;
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'hFFFF_FFFA) begin
         n_fail++;
         $display("FAIL bubble_sum dv=%b dout=%0d required 1 -6", bus.dout_valid, $signed(bus.dout));
      end
      repeat (4) begin
         @(negedge ap_clk);
         n_checks++;
         if (bus.dout_valid !== 1'b1 || bus.dout !== 32'hFFFF_FFFA || bus.ap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable dv=%b dout=%0d done=%b required 1 -6 0",
                     bus.dout_valid, $signed(bus.dout), bus.ap_done);
         end
      end
      take_result();
      n_checks++;
      if (bus.ap_done !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_done done=%b required 1", bus.ap_done);
      end
      repeat (3) begin
         @(negedge ap_clk);
         if (bus.ap_done) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL bp_single_pulse extra=%0d required 0", pulses);
      end
   endtask

   task automatic test_overflow();
      bit to;
      start_run(2);
      feed(32'h7FFF_FFFF); feed(32'h1);
      wait_valid(4, to);
      n_checks++;
      if (to || bus.dout !== 32'h8000_0000 || bus.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_wrap timeout=%b dout=%h ovf=%b required 80000000 1", to, bus.dout, bus.ovf);
      end
      take_result();
      n_checks++;
      if (bus.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky ovf=%b required 1", bus.ovf);
      end
      start_run(1);
      n_checks++;
      if (bus.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear_on_start ovf=%b required 0", bus.ovf);
      end
      feed(32'd5);
      wait_valid(4, to);
      n_checks++;
      if (to || bus.dout !== 32'd5 || bus.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL after_ovf_run timeout=%b dout=%0d ovf=%b required 5 0", to, $signed(bus.dout), bus.ovf);
      end
      take_result();
   endtask

   task automatic test_zero_len();
      start_run(0);
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== '0 || bus.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len dv=%b dout=%h ovf=%b required 1 00000000 0", bus.dout_valid, bus.dout, bus.ovf);
      end
      take_result();
      n_checks++;
      if (bus.ap_done !== 1'b1 || bus.ap_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_len_done done=%b idle=%b required 1 1", bus.ap_done, bus.ap_idle);
      end
   endtask

   task automatic test_start_misuse();
      start_run(3);
      bus.ap_start = 1'b1;
      bus.len      = LW'(1);
      feed(32'd10); feed(32'd20);
      bus.ap_start = 1'b0;
      n_checks++;
      if (bus.dout_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_accum dv=%b dr=%b required 0 1", bus.dout_valid, bus.din_ready);
      end
      feed(32'd30);
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'd60) begin
         n_fail++;
         $display("FAIL misuse_sum dv=%b dout=%0d required 1 60", bus.dout_valid, $signed(bus.dout));
      end
      bus.ap_start = 1'b1;
      bus.len      = '0;
      repeat (2) @(negedge ap_clk);
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== 32'd60 || bus.ap_idle !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_output dv=%b dout=%0d idle=%b required 1 60 0",
                  bus.dout_valid, $signed(bus.dout), bus.ap_idle);
      end
      bus.ap_start = 1'b0;
      take_result();
      n_checks++;
      if (bus.ap_done !== 1'b1) begin
         n_fail++;
         $display("FAIL misuse_done done=%b required 1", bus.ap_done);
      end
   endtask

   task automatic test_back_to_back();
      int lens[10];
      int exp_sum[10];
      int total   = 0;
      int base    = 0;
      int st      = 0;
      int res     = 0;
      int p       = 0;
      int cyc     = 0;
      int end_cyc = -1;
      int bad     = 0;
      for (int r = 0; r < 10; r++) begin
         lens[r]    = int'($urandom_range(1, 6));
         exp_sum[r] = 0;
         for (int j = 0; j < lens[r]; j++) exp_sum[r] += (base + j) * 37 - 100;
         base  += lens[r];
         total += lens[r] + 2;
      end
      bus.dout_ready = 1'b1;
      bus.din_valid  = 1'b1;
      while (res < 10 && cyc < 500) begin
         if (bus.ap_idle && st < 10) begin
            bus.ap_start = 1'b1;
            bus.len      = LW'(lens[st]);
            st++;
         end
         if (bus.din_ready) begin
            bus.din = DW'(p * 37 - 100);
            p++;
         end else begin
            bus.din = 32'hDEAD_BEEF;
         end
         if (bus.dout_valid) begin
            n_checks++;
            if (bus.dout !== AW'(exp_sum[res])) begin
               n_fail++;
               $display("FAIL b2b_run%0d dout=%0d required %0d", res, $signed(bus.dout), exp_sum[res]);
            end
            res++;
            if (res == 10) end_cyc = cyc;
         end
         if (bus.ap_done && !bus.ap_idle) bad++;
         @(negedge ap_clk);
         cyc++;
      end
      idle_inputs();
      n_checks++;
      if (res != 10 || end_cyc != total - 1 || p != base || bad != 0) begin
         n_fail++;
         $display("FAIL b2b_timing results=%0d end_cycle=%0d products=%0d done_not_idle=%0d required 10 %0d %0d 0",
                  res, end_cyc, p, bad, total - 1, base);
      end
      @(negedge ap_clk);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_zero_len();
      test_start_misuse();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/kernel_prod_accum.md
# kernel_prod_accum

Streaming accumulator downstream of the kernel's 32-bit signed multiplier. Each product the multiplier emits is summed into a running signed total. After a programmed number of products, the block presents the total as the kernel's dot-product result. It adds the handshaking, element counting and result buffering that the purely combinational multiplier stage does not provide.

## Interface
- DIN_WIDTH, 32, width of each signed product accepted
- ACC_WIDTH, 32, width of the signed accumulator and result; must be ≥ DIN_WIDTH
- LEN_WIDTH, 16, width of the element-count input
- ap_clk  in  1  clock; all logic is rising-edge
- ap_rst_n  in  1  reset; asynchronous, active-low
- ap_start  in  1  start request, sampled only in IDLE
- len  in  LEN_WIDTH  number of products to sum, unsigned; latched on accepted start
- din  in  DIN_WIDTH  signed product from the multiplier
- din_valid  in  1  din is valid
- din_ready  out  1  block accepts din this cycle
- dout  out  ACC_WIDTH  signed accumulated result
- dout_valid  out  1  dout is valid
- dout_ready  in  1  consumer accepts dout
- ovf  out  1  sticky signed-overflow flag for the current/last result
- ap_idle  out  1  block is in IDLE
- ap_done  out  1  one-cycle pulse when the result handshake completes

## Operation
- The FSM has three states: IDLE, ACCUM and OUTPUT.
- IDLE:
  - ap_idle=1, din_ready=0, dout_valid=0.
  - When ap_start=1, latch len into the remaining counter, clear acc and ovf.
  - Next state is ACCUM if len≠0. If len=0, next state is OUTPUT with dout=0.
- ACCUM:
  - din_ready=1.
  - A handshake is din_valid & din_ready. On each handshake:
    - acc ← acc + sign_extend(din).
    - remaining ← remaining−1.
  - When the handshake consumes the last element (remaining=1), next state is OUTPUT.
  - Cycles without din_valid hold all state.
- OUTPUT:
  - dout_valid=1, and dout=acc is held stable.
  - On dout_valid & dout_ready: ap_done pulses for one cycle, then the FSM returns to IDLE.
- Arithmetic:
  - The sum wraps modulo 2^ACC_WIDTH; there is no saturation.
  - ovf is set when an add overflows in the signed sense: both operands share a sign and the result sign differs.
  - ovf stays set until the next accepted start.
- ap_start outside IDLE is ignored.
- din outside ACCUM is not consumed, because din_ready=0.

## Timing
- Reset values:
  - state=IDLE, acc=0, remaining=0, ovf=0.
  - dout=0, dout_valid=0, din_ready=0, ap_done=0, ap_idle=1.
- Reset asserted mid-operation aborts immediately and returns to the reset values. No partial result is emitted.
- Start: ap_start sampled high at edge t moves the FSM to ACCUM at t+1, so din_ready=1 in cycle t+1.
- Throughput is one product per cycle under continuous din_valid.
- Latency: if the last product is accepted at edge k, then dout_valid=1 in cycle k+1 with the final sum.
- A block started at edge s with N≥1 back-to-back products therefore shows dout_valid at s+N+1.
- len=0: dout_valid=1 in the cycle after start, with dout=0 and ovf=0.
- Result handshake: dout_ready may be held low indefinitely; dout stays stable while it is low.
  - ap_done=1 in the cycle after the dout handshake edge, coincident with ap_idle=1.
  - A new ap_start is accepted in that same cycle.
- din_ready, dout_valid and ap_idle are decoded from the registered state; there is no combinational path from input to output.

## Test plan
- Reset and idle:
  - Stimulus: assert ap_rst_n=0 mid-ACCUM after 3 of 5 products, then release.
  - Required response: all outputs at reset values, ap_idle=1, no dout_valid.
  - Stimulus: new start with len=2 and products 4, 5.
  - Required response: dout=9.
- Basic dot product:
  - Stimulus: len=4, din=3, −7, 10, 100 back-to-back.
  - Required response: dout=106, ovf=0, dout_valid exactly 5 cycles after the start edge.
- Backpressure and bubbles:
  - Stimulus: len=3, din_valid toggled 1,0,0,1,0,1 with products −1, −2, −3; dout_ready held low for 4 cycles.
  - Required response: dout=−6 held stable throughout; single ap_done pulse after dout_ready rises.
- Overflow wrap:
  - Stimulus: ACC_WIDTH=32, len=2, din=0x7FFFFFFF then 1.
  - Required response: dout=0x80000000, ovf=1.
  - Stimulus: next run with len=1, din=5.
  - Required response: ovf=0, dout=5.
- Zero length and start misuse:
  - Stimulus: len=0.
  - Required response: dout=0 valid in the cycle after start.
  - Stimulus: ap_start pulsed during ACCUM and during OUTPUT.
  - Required response: ignored; remaining count and result unaffected.
- Back-to-back runs:
  - Stimulus: ap_start held high continuously.
  - Required response: the next run starts in the ap_done cycle, with no lost or duplicated products across 10 random-length runs checked against a reference sum.
